// File: rtl/hack_mem_pkg.sv
// Shared widths, depth and controller state encoding for the Hack 4K-word RAM store.
package hack_mem_pkg;

    localparam int RAM4K_ADDR_W = 12;
    localparam int HACK_WORD_W  = 16;
    localparam int RAM4K_DEPTH  = 4096;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie the port not granted most recently wins.
module rr_arbiter_2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1
);

    // 1 when port 1 holds the most recent grant; reset value lets port 0 win the first tie
    logic r_last_gnt1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (advance) begin
            if (req0 && req1) begin
                gnt0 = r_last_gnt1;
                gnt1 = !r_last_gnt1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt1 <= 1'b1;
        end else if (gnt0) begin
            r_last_gnt1 <= 1'b0;
        end else if (gnt1) begin
            r_last_gnt1 <= 1'b1;
        end
    end

endmodule

// File: rtl/ram_4k_arbiter.sv
// Single-port controller for the 4K x 16 RAM: post-reset clear sweep, then
// round-robin sharing between two requesters with one-cycle read return.
module ram_4k_arbiter
    import hack_mem_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [RAM4K_ADDR_W-1:0] addr0,
    input  logic [RAM4K_ADDR_W-1:0] addr1,
    input  logic [HACK_WORD_W-1:0]  wdata0,
    input  logic [HACK_WORD_W-1:0]  wdata1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    rvalid0,
    output logic                    rvalid1,
    output logic [HACK_WORD_W-1:0]  rdata0,
    output logic [HACK_WORD_W-1:0]  rdata1,
    output logic                    clearing,
    output logic [HACK_WORD_W-1:0]  ram_in,
    output logic [RAM4K_ADDR_W-1:0] ram_address,
    output logic                    ram_load,
    input  logic [HACK_WORD_W-1:0]  ram_out
);

    arb_state_e              r_state;
    arb_state_e              w_state_next;
    logic [RAM4K_ADDR_W-1:0] r_clr_cnt;
    logic                    w_clr_last;
    logic                    w_advance;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    r_rvalid0;
    logic                    r_rvalid1;
    logic                    w_rvalid0;
    logic                    w_rvalid1;

    assign w_clr_last = (r_clr_cnt == RAM4K_ADDR_W'(RAM4K_DEPTH - 1));
    assign w_advance  = !reset && (r_state == ST_ARB);

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .advance (w_advance),
        .gnt0    (w_gnt0),
        .gnt1    (w_gnt1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_ARB;
            end
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_next = ST_ARB;
            ST_ARB:   w_state_next = ST_ARB;
            default:  w_state_next = ST_ARB;
        endcase
    end

    // Counter parks at the last address so it never wraps once the sweep ends
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR && !w_clr_last) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        clearing    = 1'b0;
        if (reset) begin
            clearing = CLEAR_ON_RESET;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    clearing    = 1'b1;
                    ram_load    = 1'b1;
                    ram_address = r_clr_cnt;
                end
                ST_ARB: begin
                    if (w_gnt0) begin
                        ram_address = addr0;
                        ram_in      = wdata0;
                        ram_load    = we0;
                    end else if (w_gnt1) begin
                        ram_address = addr1;
                        ram_in      = wdata1;
                        ram_load    = we1;
                    end
                end
                default: clearing = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 && !we0;
            r_rvalid1 <= w_gnt1 && !we1;
        end
    end

    // A reset landing in the return cycle drops the pending read
    assign w_rvalid0 = r_rvalid0 && !reset;
    assign w_rvalid1 = r_rvalid1 && !reset;

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = w_rvalid0;
    assign rvalid1 = w_rvalid1;
    assign rdata0  = w_rvalid0 ? ram_out : '0;
    assign rdata1  = w_rvalid1 ? ram_out : '0;

endmodule

// File: tb/tb_ram_4k_arbiter.sv
// Scoreboard bench for ram_4k_arbiter: clear sweep, round-robin grants, read return, resets.
module tb_ram_4k_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with clear-on-reset
    logic        reset, req0, req1, we0, we1;
    logic [11:0] addr0, addr1, ram_address;
    logic [15:0] wdata0, wdata1, rdata0, rdata1, ram_in, ram_out;
    logic        gnt0, gnt1, rvalid0, rvalid1, clearing, ram_load;

    ram_4k_arbiter #(.CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .clearing(clearing),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    // DUT without clear sweep; RAM output tied to a marker value
    logic        b_reset, b_req0, b_req1, b_we0, b_we1;
    logic [11:0] b_addr0, b_addr1, b_ram_address;
    logic [15:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_ram_in, b_ram_out;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_clearing, b_ram_load;

    assign b_ram_out = 16'h5A5A;

    ram_4k_arbiter #(.CLEAR_ON_RESET(1'b0)) u_dut_nc (
        .clk(clk), .reset(b_reset),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1), .clearing(b_clearing),
        .ram_in(b_ram_in), .ram_address(b_ram_address), .ram_load(b_ram_load),
        .ram_out(b_ram_out)
    );

    // RAM model with one-cycle registered read; fill_req pre-loads every word with 0xFFFF
    logic [15:0] ram_mem [0:4095];
    logic        fill_req;
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= 16'hFFFF;
        end else if (ram_load) begin
            ram_mem[ram_address] <= ram_in;
        end
        ram_out <= ram_mem[ram_address];
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rdata_leak = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          port;
        logic [15:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     sb_q[$];
    rd_exp_t     mon_e;
    logic [15:0] model [0:4095];

    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_spurious_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("sb_port", {30'd0, rvalid1, rvalid0}, (mon_e.port == 0) ? 32'd1 : 32'd2);
                check_eq("sb_cycle", cyc, mon_e.due);
                check_eq("sb_rdata", (mon_e.port == 0) ? rdata0 : rdata1, mon_e.data);
                $display("read return port%0d data=0x%04h cycle=%0d", mon_e.port, mon_e.data, cyc);
            end
        end
        if ((!rvalid0 && rdata0 != 16'h0) || (!rvalid1 && rdata1 != 16'h0)) rdata_leak++;
    end

    // Drive one cycle of requests, check the expected grant (-1 = none) and RAM pins
    task automatic step(input string tag,
                        input logic r0, input logic w0, input logic [11:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [11:0] a1, input logic [15:0] d1,
                        input int exp_g);
        rd_exp_t e;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        check_eq({tag, "_gnt"}, {30'd0, gnt1, gnt0},
                 (exp_g == 0) ? 32'd1 : (exp_g == 1) ? 32'd2 : 32'd0);
        if (exp_g == 0 || exp_g == 1) begin
            logic        w;
            logic [11:0] a;
            logic [15:0] d;
            w = (exp_g == 0) ? w0 : w1;
            a = (exp_g == 0) ? a0 : a1;
            d = (exp_g == 0) ? d0 : d1;
            check_eq({tag, "_addr"}, {20'd0, ram_address}, {20'd0, a});
            check_eq({tag, "_load"}, {31'd0, ram_load}, {31'd0, w});
            if (w) begin
                check_eq({tag, "_din"}, {16'd0, ram_in}, {16'd0, d});
                model[a] = d;
            end else begin
                e.port = exp_g;
                e.data = model[a];
                e.due  = cyc + 1;
                sb_q.push_back(e);
            end
            $display("grant port%0d %s addr=0x%03h cycle=%0d", exp_g, w ? "write" : "read", a, cyc);
        end else begin
            check_eq({tag, "_idle_pins"}, {3'd0, ram_load, ram_address, ram_in}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    // Count clear cycles with the right address; optionally require the sweep to be over afterwards
    task automatic clear_sweep(input string tag, input int n_cycles, input logic expect_exit);
        int good;
        good = 0;
        for (int i = 0; i < n_cycles; i++) begin
            @(negedge clk);
            if (ram_load && ram_address == 12'(i) && ram_in == 16'h0 && clearing && !gnt0 && !gnt1)
                good++;
            @(posedge clk); #1;
        end
        check_eq({tag, "_cycles"}, good, n_cycles);
        if (expect_exit) check_eq({tag, "_clearing_fell"}, {31'd0, clearing}, 32'd0);
        $display("clear sweep %s: %0d good cycles of %0d", tag, good, n_cycles);
    endtask

    initial begin
        reset = 1'b1; fill_req = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        b_reset = 1'b1; b_req0 = 1'b0; b_req1 = 1'b0; b_we0 = 1'b0; b_we1 = 1'b0;
        b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
        for (int i = 0; i < 4096; i++) model[i] = 16'h0;

        @(posedge clk); #1;
        fill_req = 1'b0;
        // Requests for the mixed-contention test are held through reset and the sweep
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h200;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h200; wdata1 = 16'h00FF;
        @(negedge clk);
        check_eq("rst_clearing", {31'd0, clearing}, 32'd1);
        check_eq("rst_pins", {28'd0, ram_load, gnt1, gnt0, rvalid0 | rvalid1}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        clear_sweep("clr", 4096, 1'b1);

        // Mixed contention on the first cycle after the sweep
        step("mix0", 1'b1, 1'b0, 12'h200, 16'h0000, 1'b1, 1'b1, 12'h200, 16'h00FF, 0);
        step("mix1", 1'b1, 1'b0, 12'h200, 16'h0000, 1'b1, 1'b1, 12'h200, 16'h00FF, 1);
        step("mix2", 1'b1, 1'b0, 12'h200, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 0);

        // Single-port write then read, back to back on port 0
        step("sp_wr", 1'b1, 1'b1, 12'hABC, 16'h1234, 1'b0, 1'b0, 12'h000, 16'h0000, 0);
        step("sp_rd", 1'b1, 1'b0, 12'hABC, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 0);
        step("idle0", 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, -1);

        // Port 1 write leaves port 0 as the next tie winner
        step("p1_wr", 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h300, 16'hBEEF, 1);
        for (int k = 0; k < 6; k++)
            step("cont", 1'b1, 1'b0, 12'hABC, 16'h0000, 1'b1, 1'b0, 12'h300, 16'h0000, k % 2);
        step("idle1", 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, -1);
        step("idle2", 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, -1);
        check_eq("sb_drained", sb_q.size(), 32'd0);

        // Reset in the cycle after a read grant drops that read
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'hABC; req1 = 1'b0;
        @(negedge clk);
        check_eq("lost_rd_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0; reset = 1'b1;
        @(negedge clk);
        check_eq("lost_rd_rvalid", {15'd0, rvalid0, rdata0}, 32'd0);
        check_eq("lost_rd_clearing", {30'd0, clearing, ram_load}, 32'd2);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset mid-clear at address 1000 restarts the full sweep
        clear_sweep("clr_part", 1000, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midclr_rst", {30'd0, clearing, ram_load}, 32'd2);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_sweep("clr_restart", 4096, 1'b1);
        step("post_clr_rd", 1'b1, 1'b0, 12'hABC, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 0);
        for (int i = 0; i < 4096; i++) model[i] = 16'h0;
        sb_q[sb_q.size() - 1].data = 16'h0000;
        step("idle3", 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, -1);
        check_eq("sb_drained2", sb_q.size(), 32'd0);
        check_eq("rdata_leak", rdata_leak, 32'd0);

        // No-clear variant: port 1 granted on the very first cycle after reset
        b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 12'h123;
        @(negedge clk);
        check_eq("nc_rst_state", {27'd0, b_clearing, b_ram_load, b_gnt1, b_gnt0, b_rvalid1}, 32'd0);
        check_eq("nc_rst_din", {16'd0, b_ram_in}, 32'd0);
        @(posedge clk); #1;
        b_reset = 1'b0;
        @(negedge clk);
        check_eq("nc_first_gnt", {29'd0, b_clearing, b_gnt1, b_gnt0}, 32'd2);
        check_eq("nc_first_addr", {20'd0, b_ram_address}, 32'h123);
        @(posedge clk); #1;
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 12'h045;
        @(negedge clk);
        check_eq("nc_rvalid1", {15'd0, b_rvalid1, b_rdata1}, {15'd0, 1'b1, 16'h5A5A});
        check_eq("nc_tie_gnt", {30'd0, b_gnt1, b_gnt0}, 32'd1);
        @(posedge clk); #1;
        b_req0 = 1'b0; b_req1 = 1'b0;
        @(negedge clk);
        check_eq("nc_rvalid0", {15'd0, b_rvalid0, b_rdata0}, {15'd0, 1'b1, 16'h5A5A});
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_4k_arbiter.md
# ram_4k_arbiter

Two-requester controller for the 4K-word, 16-bit block-RAM store. It clears the whole array after reset, then shares the single RAM port between requester 0 and requester 1 with round-robin arbitration. It returns read data with the RAM's one-cycle read latency. It sits between the RAM and its users, e.g. the CPU data port and a DMA/loader engine, and is the only driver of the RAM's `in`/`address`/`load` pins.

## Interface
Parameters:
- `CLEAR_ON_RESET`, default 1: when 1, sweep all 4096 words to 0 after reset; when 0, enter arbitration directly.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0`, `req1`  in  1  access request; held with its address/data until granted.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  12  word address.
- `wdata0`, `wdata1`  in  16  write data.
- `gnt0`, `gnt1`  out  1  combinational grant; the access executes in this cycle when `req & gnt`.
- `rvalid0`, `rvalid1`  out  1  registered; read data valid this cycle.
- `rdata0`, `rdata1`  out  16  equal to `ram_out` when the matching `rvalid` is 1, else 0.
- `clearing`  out  1  high while the clear sweep is pending or running.
- `ram_in`  out  16  to the RAM `in` pin.
- `ram_address`  out  12  to the RAM `address` pin.
- `ram_load`  out  1  to the RAM `load` pin.
- `ram_out`  in  16  from the RAM `out` pin; valid one cycle after the address is presented.

## Operation
- States: `CLEAR` and `ARB`.
  - On `reset`, go to `CLEAR` if `CLEAR_ON_RESET`=1, else to `ARB`.
  - Load the clear counter with 0.
  - Set the last-grant register to 1, so port 0 wins the first tie.
- Behaviour while `reset` is high:
  - `ram_load`=0, `gnt*`=0, `rvalid*`=0.
  - `clearing` = `CLEAR_ON_RESET`.
- `CLEAR` state:
  - Each cycle drive `ram_address`=counter, `ram_in`=0, `ram_load`=1, then increment the counter.
  - After the write to address 4095, move to `ARB` and drop `clearing`.
  - `gnt*` stays 0 throughout; requests wait.
- `ARB` state:
  - Only one requester active: grant it.
  - Both active: grant the port not granted most recently.
  - Neither active: no grant, `ram_load`=0, `ram_address`/`ram_in` driven 0.
  - The last-grant register updates only on a granted cycle.
- Granted access:
  - `ram_address`=addrX and `ram_in`=wdataX.
  - `ram_load`=weX.
  - For a read (`weX`=0), set `rvalidX` for the next cycle only.
- Read-after-write to the same address in consecutive grants returns the new data.
- Back-to-back grants to one port are allowed; a port may be granted every cycle when the other is idle.
- The counter is 12 bits; no wrap occurs because `CLEAR` exits on reaching 4095.

## Timing
- Clear duration: 4096 cycles.
  - With `reset` deasserted before edge 0, addresses 0..4095 are written on cycles 0..4095.
  - The first grant is possible on cycle 4096.
- Read latency:
  - Grant at cycle N gives `rvalidX`=1 with data at cycle N+1.
  - Throughput is one access per cycle total.
- Grant is combinational from `req*`, state and last-grant. There is no combinational path from `ram_out` to the grant outputs.
- Reset mid-clear: the sweep restarts at address 0 and `clearing` stays high.
- Reset in the cycle after a read grant: that `rvalid` is forced to 0 and the read is lost.

## Structure
- Shared package `hack_mem_pkg` holds:
  - `RAM4K_ADDR_W`=12 and `HACK_WORD_W`=16;
  - the state enum `{ST_CLEAR, ST_ARB}`;
  - `RAM4K_DEPTH`=4096.
- Sub-module `rr_arbiter_2` holds:
  - inputs `req0`, `req1`, `advance`;
  - outputs `gnt0`, `gnt1`;
  - the last-grant flop, with the same `clk`/`reset`.
- The top level holds the FSM, the clear counter, the RAM-pin mux and the `rvalid` flops.

## Test plan
- Clear sweep:
  - Pre-fill the RAM model with 0xFFFF, then reset.
  - Require `ram_load`=1 for 4096 consecutive cycles at addresses 0..4095 with `ram_in`=0.
  - Require `clearing` to fall on cycle 4096 and `gnt*`=0 throughout.
- Single-port write then read:
  - Port 0 writes 0x1234 to 0x0ABC, then reads 0x0ABC.
  - Require `rvalid0`=1 with `rdata0`=0x1234 exactly one cycle after the read grant, and `rvalid1`=0.
- Contention:
  - Both ports hold reads for 6 cycles.
  - Require grants in the order 0,1,0,1,0,1 and each `rvalid` one cycle after its grant.
- Mixed contention:
  - Port 1 writes 0x00FF to 0x0200 while port 0 reads 0x0200 in the same cycle, first cycle after clear.
  - Port 0 wins and returns 0x0000.
  - Port 1's write is granted next cycle; a port 0 re-read returns 0x00FF.
- Reset mid-clear:
  - Assert `reset` at clear address 1000 for one cycle.
  - Require the sweep to restart at address 0 and take 4096 further cycles.
- `CLEAR_ON_RESET`=0:
  - Require `clearing`=0 after reset.
  - Require a `req1` on the first cycle after reset to be granted immediately.
